// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of the sprite ROM and object lookup.
// Pipeline: grant -> stage A (lookup) -> stage B (ROM address) -> ROM_LAT
// delay line -> output register. One accept per cycle, no stalls.
// ROM_LAT must be at least 1.
module sprite_rom_arbiter #(
  parameter int          N_REQ     = 4,
  parameter int          ID_W      = 2,
  parameter int          ROM_LAT   = 1,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [6*N_REQ-1:0]  req_type,
  input  logic [11*N_REQ-1:0] req_h,
  input  logic [11*N_REQ-1:0] req_w,
  output logic [N_REQ-1:0]    req_ready,
  output logic [5:0]          obj_id,
  input  logic [10:0]         obj_h,
  input  logic [10:0]         obj_w,
  input  logic [18:0]         obj_addr,
  output logic [18:0]         rom_addr,
  input  logic [11:0]         rom_data,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [11:0]         rsp_data,
  output logic                rsp_transp,
  output logic                rsp_oob
);

  logic [ID_W-1:0] last_q, last_d, cand, gnt_idx;
  logic            gnt_found;

  logic            a_vld_q, a_vld_d;
  logic [ID_W-1:0] a_id_q, a_id_d;
  logic [5:0]      a_type_q, a_type_d;
  logic [10:0]     a_h_q, a_h_d, a_w_q, a_w_d;

  logic [21:0]     prod;
  logic [18:0]     addr;
  logic            oob;

  logic            b_vld_q, b_vld_d, b_oob_q, b_oob_d;
  logic [ID_W-1:0] b_id_q, b_id_d;
  logic [18:0]     rom_addr_q, rom_addr_d;

  logic            dl_vld_q [ROM_LAT];
  logic            dl_vld_d [ROM_LAT];
  logic            dl_oob_q [ROM_LAT];
  logic            dl_oob_d [ROM_LAT];
  logic [ID_W-1:0] dl_id_q  [ROM_LAT];
  logic [ID_W-1:0] dl_id_d  [ROM_LAT];

  logic            rsp_valid_q, rsp_valid_d, rsp_transp_q, rsp_transp_d, rsp_oob_q, rsp_oob_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [11:0]     rsp_data_q, rsp_data_d;

  // Round-robin grant: first valid requester after last, gated off during reset.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_q;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (rst) gnt_found = 1'b0;
    req_ready = gnt_found ? (N_REQ'(1) << gnt_idx) : '0;
    last_d    = gnt_found ? gnt_idx : last_q;
  end

  // Stage A capture of the granted request; payload holds while idle.
  always_comb begin
    a_vld_d  = gnt_found;
    a_id_d   = a_id_q;
    a_type_d = a_type_q;
    a_h_d    = a_h_q;
    a_w_d    = a_w_q;
    if (gnt_found) begin
      a_id_d   = gnt_idx;
      a_type_d = req_type[int'(gnt_idx)*6 +: 6];
      a_h_d    = req_h[int'(gnt_idx)*11 +: 11];
      a_w_d    = req_w[int'(gnt_idx)*11 +: 11];
    end
  end

  assign obj_id = a_type_q;

  // Flat address (wraps mod 2^19) and range check against the looked-up object.
  always_comb begin
    prod = 22'(a_h_q) * 22'(obj_w);
    addr = 19'({3'b0, obj_addr} + prod + {11'b0, a_w_q});
    oob  = (a_h_q >= obj_h) | (a_w_q >= obj_w);
  end

  // Stage B: ROM address register, held between fetches; oob still drives it.
  always_comb begin
    b_vld_d    = a_vld_q;
    b_id_d     = a_vld_q ? a_id_q : b_id_q;
    b_oob_d    = a_vld_q ? oob : b_oob_q;
    rom_addr_d = a_vld_q ? addr : rom_addr_q;
  end

  // Side-band delay line keeping id/oob aligned with ROM read data.
  always_comb begin
    dl_vld_d    = dl_vld_q;
    dl_id_d     = dl_id_q;
    dl_oob_d    = dl_oob_q;
    dl_vld_d[0] = b_vld_q;
    dl_id_d[0]  = b_id_q;
    dl_oob_d[0] = b_oob_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_id_d[i]  = dl_id_q[i-1];
      dl_oob_d[i] = dl_oob_q[i-1];
    end
  end

  // Response register: out-of-range pixels are forced to zero and transparent.
  always_comb begin
    rsp_valid_d  = dl_vld_q[ROM_LAT-1];
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_transp_d = rsp_transp_q;
    rsp_oob_d    = rsp_oob_q;
    if (dl_vld_q[ROM_LAT-1]) begin
      rsp_id_d     = dl_id_q[ROM_LAT-1];
      rsp_oob_d    = dl_oob_q[ROM_LAT-1];
      rsp_data_d   = dl_oob_q[ROM_LAT-1] ? 12'h000 : rom_data;
      rsp_transp_d = dl_oob_q[ROM_LAT-1] | (rom_data == KEY_COLOR);
    end
  end

  // State registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= ID_W'(N_REQ-1);
      a_vld_q      <= 1'b0;
      a_id_q       <= '0;
      a_type_q     <= '0;
      a_h_q        <= '0;
      a_w_q        <= '0;
      b_vld_q      <= 1'b0;
      b_id_q       <= '0;
      b_oob_q      <= 1'b0;
      rom_addr_q   <= '0;
      dl_vld_q     <= '{default: 1'b0};
      dl_id_q      <= '{default: '0};
      dl_oob_q     <= '{default: 1'b0};
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_transp_q <= 1'b0;
      rsp_oob_q    <= 1'b0;
    end else begin
      last_q       <= last_d;
      a_vld_q      <= a_vld_d;
      a_id_q       <= a_id_d;
      a_type_q     <= a_type_d;
      a_h_q        <= a_h_d;
      a_w_q        <= a_w_d;
      b_vld_q      <= b_vld_d;
      b_id_q       <= b_id_d;
      b_oob_q      <= b_oob_d;
      rom_addr_q   <= rom_addr_d;
      dl_vld_q     <= dl_vld_d;
      dl_id_q      <= dl_id_d;
      dl_oob_q     <= dl_oob_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_transp_q <= rsp_transp_d;
      rsp_oob_q    <= rsp_oob_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_transp = rsp_transp_q;
  assign rsp_oob    = rsp_oob_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model (grant rule, queues).
module tb_sprite_rom_arbiter;
  localparam int N = 4, IW = 2, LAT = 1;
  localparam logic [11:0] KEY = 12'hF0F;

  logic            clk = 1'b0, rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [6*N-1:0]  req_type = '0;
  logic [11*N-1:0] req_h = '0, req_w = '0;
  logic [N-1:0]    req_ready;
  logic [5:0]      obj_id;
  logic [10:0]     obj_h, obj_w;
  logic [18:0]     obj_addr, rom_addr;
  logic [11:0]     rom_data, rsp_data;
  logic            rsp_valid, rsp_transp, rsp_oob;
  logic [IW-1:0]   rsp_id;

  logic [10:0] tab_h [64];
  logic [10:0] tab_w [64];
  logic [18:0] tab_a [64];
  logic [11:0] rom_pipe [LAT];

  int checks = 0, errors = 0, cyc = 0;

  sprite_rom_arbiter #(.N_REQ(N), .ID_W(IW), .ROM_LAT(LAT), .KEY_COLOR(KEY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type), .req_h(req_h),
    .req_w(req_w), .req_ready(req_ready), .obj_id(obj_id), .obj_h(obj_h), .obj_w(obj_w),
    .obj_addr(obj_addr), .rom_addr(rom_addr), .rom_data(rom_data), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_transp(rsp_transp), .rsp_oob(rsp_oob));

  always #5 clk = ~clk;

  // Object lookup is combinational; the ROM is a LAT-deep registered read.
  assign obj_h    = tab_h[obj_id];
  assign obj_w    = tab_w[obj_id];
  assign obj_addr = tab_a[obj_id];

  function automatic logic [11:0] rom_fn(input logic [18:0] a);
    if (a == 19'd153) return 12'h123;
    if (a == 19'd200) return KEY;
    if (a[3:0] == 4'hF) return KEY;
    return a[11:0] ^ 12'h3C6;
  endfunction

  always @(posedge clk) begin
    rom_pipe[0] <= rom_fn(rom_addr);
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Grant rule: first valid requester after last, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last+k)%N]) return (last+k)%N;
    return -1;
  endfunction

  typedef struct { int due; logic [IW-1:0] id; logic [11:0] data; logic tr; logic oob; } rsp_t;
  typedef struct { int due; logic [18:0] a; } ra_t;
  rsp_t rq[$];
  ra_t  aq[$];
  int            m_last = N-1;
  logic [18:0]   m_rom = '0;
  logic          m_rv = 1'b0, m_tr = 1'b0, m_oob = 1'b0;
  logic [IW-1:0] m_id = '0;
  logic [11:0]   m_data = '0;

  // Model: each accepted fetch schedules its ROM address and its response.
  initial begin
    int g, t;
    int unsigned a, h, w;
    logic [11:0] d;
    logic o;
    forever begin
      @(posedge clk);
      cyc++;
      m_rv = 1'b0;
      if (rst) begin
        m_last = N-1; m_rom = '0; rq.delete(); aq.delete();
      end else begin
        if (aq.size() > 0 && aq[0].due == cyc) begin
          m_rom = aq[0].a; void'(aq.pop_front());
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
          m_rv = 1'b1; m_id = rq[0].id; m_data = rq[0].data; m_tr = rq[0].tr; m_oob = rq[0].oob;
          void'(rq.pop_front());
        end
        g = pick(req_valid, m_last);
        if (g >= 0) begin
          t = int'(req_type[g*6 +: 6]);
          h = req_h[g*11 +: 11];
          w = req_w[g*11 +: 11];
          a = (tab_a[t] + h * tab_w[t] + w) & 32'h7FFFF;
          o = (h >= tab_h[t]) || (w >= tab_w[t]);
          d = rom_fn(a[18:0]);
          aq.push_back('{due: cyc+1, a: a[18:0]});
          rq.push_back('{due: cyc+2+LAT, id: IW'(g), data: o ? 12'h000 : d, tr: o | (d == KEY), oob: o});
          m_last = g;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    int g;
    forever begin
      @(negedge clk);
      g = pick(req_valid, m_last);
      chk("req_ready", 32'(req_ready), (rst || g < 0) ? 32'd0 : (32'd1 << g));
      chk("rom_addr", 32'(rom_addr), 32'(m_rom));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      if (m_rv) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_data", 32'(rsp_data), 32'(m_data));
        chk("rsp_transp", 32'(rsp_transp), 32'(m_tr));
        chk("rsp_oob", 32'(rsp_oob), 32'(m_oob));
      end
    end
  end

  task automatic do_reset();
    req_valid = '0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // One isolated fetch with literal expectations (ROM_LAT = 1 timing).
  task automatic single(input int r, input int t, input int h, input int w,
                        input logic [18:0] ea, input logic [11:0] ed, input logic etr, input logic eoob);
    req_valid = '0; req_valid[r] = 1'b1;
    req_type[r*6 +: 6] = 6'(t); req_h[r*11 +: 11] = 11'(h); req_w[r*11 +: 11] = 11'(w);
    @(negedge clk); chk("d_ready", 32'(req_ready), 32'd1 << r);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); @(negedge clk); chk("d_rom_addr", 32'(rom_addr), 32'(ea));
    @(posedge clk); @(negedge clk); chk("d_rsp_early", 32'(rsp_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("d_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("d_rsp_id", 32'(rsp_id), 32'(r));
    chk("d_rsp_data", 32'(rsp_data), 32'(ed));
    chk("d_rsp_transp", 32'(rsp_transp), 32'(etr));
    chk("d_rsp_oob", 32'(rsp_oob), 32'(eoob));
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin tab_h[i] = '0; tab_w[i] = '0; tab_a[i] = '0; end
    // Reset: grant gated while rst high, outputs cleared, requester 0 first.
    req_valid = '1;
    @(negedge clk); chk("rst_gate", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_flags", 32'({rsp_transp, rsp_oob}), 32'd0);
    rst = 1'b0; #1;
    chk("rst_first_grant", 32'(req_ready), 32'd1);
    req_valid = '0;
    @(posedge clk); #1;

    tab_a[5] = 19'd100;     tab_h[5] = 11'd16; tab_w[5] = 11'd16;
    tab_a[7] = 19'd200;     tab_h[7] = 11'd4;  tab_w[7] = 11'd4;
    tab_a[8] = 19'd0;       tab_h[8] = 11'd16; tab_w[8] = 11'd16;
    tab_a[9] = 19'd1000;    tab_h[9] = 11'd16; tab_w[9] = 11'd0;
    tab_a[10] = 19'h7FFF0;  tab_h[10] = 11'd16; tab_w[10] = 11'd32;
    single(2, 5, 3, 5, 19'd153, 12'h123, 1'b0, 1'b0);
    single(1, 7, 0, 0, 19'd200, 12'hF0F, 1'b1, 1'b0);
    single(0, 8, 2, 16, 19'd48, 12'h000, 1'b1, 1'b1);
    single(3, 9, 0, 0, 19'd1000, 12'h000, 1'b1, 1'b1);
    single(2, 10, 0, 20, 19'h00004, 12'h3C2, 1'b0, 1'b0);

    // Round robin: all requesters held valid for 8 accepts.
    do_reset();
    for (int r = 0; r < N; r++) begin
      req_type[r*6 +: 6] = 6'd5; req_h[r*11 +: 11] = 11'(r); req_w[r*11 +: 11] = 11'(r+1);
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); chk("rr_grant", 32'(req_ready), 32'd1 << (k % N));
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (6) begin @(posedge clk); #1; end

    // Reset mid-flight: three fetches in the pipe are discarded.
    do_reset();
    req_valid = 4'b1110;
    repeat (3) begin @(posedge clk); #1; end
    req_valid = '0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) begin @(negedge clk); chk("mf_quiet", 32'(rsp_valid), 32'd0); end
    req_valid = '1; #1;
    chk("mf_first_grant", 32'(req_ready), 32'd1);
    req_valid = '0;
    @(posedge clk); #1;

    // Randomized traffic, occasional reset, checked by the model.
    for (int i = 0; i < 16; i++) begin
      tab_h[i] = 11'($urandom_range(0, 24));
      tab_w[i] = 11'($urandom_range(0, 24));
      tab_a[i] = 19'($urandom);
    end
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
      for (int r = 0; r < N; r++) begin
        req_type[r*6 +: 6] = 6'($urandom_range(0, 15));
        req_h[r*11 +: 11]  = 11'($urandom_range(0, 28));
        req_w[r*11 +: 11]  = 11'($urandom_range(0, 28));
      end
      rst = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    req_valid = '0; rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
